// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block: divider state encoding,
// the common operand width and width-generic constant helpers.
package arith_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } div_state_e;

   // Helpers return 64-bit patterns; callers keep the low w bits (w <= 64).
   function automatic logic [63:0] min_int(input int w);
      return 64'd1 << (w - 1);
   endfunction

   function automatic logic [63:0] all_ones(input int w);
      return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/booth_divider_step.sv
// One radix-2 non-restoring division step on a WIDTH+1 bit partial remainder.
module booth_divider_step
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic signed [WIDTH:0]   rem_i,
   input  logic        [WIDTH-1:0] q_i,
   input  logic        [WIDTH-1:0] d_i,
   output logic signed [WIDTH:0]   rem_o,
   output logic        [WIDTH-1:0] q_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] d_ext;

   always_comb begin
      shifted = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
      d_ext   = {1'b0, d_i};
      // A negative remainder is repaired by adding, a non-negative one is reduced by subtracting.
      rem_o   = rem_i[WIDTH] ? $signed(shifted + d_ext) : $signed(shifted - d_ext);
      q_o     = {q_i[WIDTH-2:0], ~rem_o[WIDTH]};
   end

endmodule

// File: rtl/booth_divider.sv
// Iterative signed divider: sign/magnitude pre-processing, one quotient bit
// per clock, remainder correction and sign restoration, held results.
module booth_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic                    busy,
   output logic                    done,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    div_by_zero,
   output logic                    overflow
);

   localparam int              CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
   localparam logic [63:0]     MIN64  = min_int(WIDTH);
   localparam logic [63:0]     ONES64 = all_ones(WIDTH);
   localparam logic [WIDTH-1:0] MIN_V  = MIN64[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONES_V = ONES64[WIDTH-1:0];

   div_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic signed [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic signed [WIDTH:0] rem_q, rem_d, step_rem;
   logic [WIDTH-1:0] qr_q, qr_d, step_q, dm_q, dm_d;
   logic [WIDTH-1:0] a_mag, b_mag, r_mag;
   logic q_sign_q, q_sign_d, r_sign_q, r_sign_d;
   logic spec_dz_q, spec_dz_d, spec_ov_q, spec_ov_d;
   logic signed [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
   logic dz_q, dz_d, ov_q, ov_d;

   booth_divider_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .q_i   (qr_q),
      .d_i   (dm_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // MIN_INT negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
   assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
   assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;
   assign r_mag = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dm_q) : rem_q[WIDTH-1:0];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      qr_d      = qr_q;
      dm_d      = dm_q;
      q_sign_d  = q_sign_q;
      r_sign_d  = r_sign_q;
      spec_dz_d = spec_dz_q;
      spec_ov_d = spec_ov_q;
      quo_d     = quo_q;
      rmd_d     = rmd_q;
      dz_d      = dz_q;
      ov_d      = ov_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_PREP;
               a_d     = dividend;
               b_d     = divisor;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            q_sign_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
            r_sign_d  = a_q[WIDTH-1];
            rem_d     = '0;
            qr_d      = a_mag;
            dm_d      = b_mag;
            cnt_d     = '0;
            spec_dz_d = (b_q == '0);
            spec_ov_d = (a_q == MIN_V) && (b_q == ONES_V);
            // Special cases skip the iterations and resolve in FIX.
            state_d   = (spec_dz_d || spec_ov_d) ? S_FIX : S_ITER;
         end
         S_ITER: begin
            rem_d = step_rem;
            qr_d  = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            if (spec_dz_q) begin
               quo_d = ONES_V;
               rmd_d = a_q;
               dz_d  = 1'b1;
               ov_d  = 1'b0;
            end else if (spec_ov_q) begin
               quo_d = MIN_V;
               rmd_d = '0;
               dz_d  = 1'b0;
               ov_d  = 1'b1;
            end else begin
               quo_d = q_sign_q ? -qr_q : qr_q;
               rmd_d = r_sign_q ? -r_mag : r_mag;
               dz_d  = 1'b0;
               ov_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         qr_q      <= '0;
         dm_q      <= '0;
         q_sign_q  <= 1'b0;
         r_sign_q  <= 1'b0;
         spec_dz_q <= 1'b0;
         spec_ov_q <= 1'b0;
         quo_q     <= '0;
         rmd_q     <= '0;
         dz_q      <= 1'b0;
         ov_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         qr_q      <= qr_d;
         dm_q      <= dm_d;
         q_sign_q  <= q_sign_d;
         r_sign_q  <= r_sign_d;
         spec_dz_q <= spec_dz_d;
         spec_ov_q <= spec_ov_d;
         quo_q     <= quo_d;
         rmd_q     <= rmd_d;
         dz_q      <= dz_d;
         ov_q      <= ov_d;
      end
   end

   assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
   assign done        = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dz_q;
   assign overflow    = ov_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: vector table, hand sequences and
// random operations, all checked through an expected-result queue.
module tb_booth_divider;

   localparam int W = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic signed [W-1:0] dividend, divisor;
   logic                busy, done, div_by_zero, overflow;
   logic signed [W-1:0] quotient, remainder;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
      int           lat;
   } vec_t;

   vec_t sb[$];
   int   total = 0;
   int   bad   = 0;

   booth_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic dz, input logic ov, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat;
      return v;
   endfunction

   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      logic signed [W-1:0] sa, sd;
      sa = a; sd = b;
      v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0; v.lat = 35;
      if (b == '0) begin
         v.q = '1; v.r = a; v.dz = 1'b1; v.lat = 3;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         v.q = 32'h8000_0000; v.r = '0; v.ov = 1'b1; v.lat = 3;
      end else begin
         v.q = sa / sd;
         v.r = sa % sd;
      end
      return v;
   endfunction

   // Caller is just past the accepting edge; counts that edge as 1.
   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", lat);
         sb.delete();
      end
   endtask

   task automatic run(input vec_t v);
      int lat;
      @(negedge clk);
      dividend = v.a;
      divisor  = v.b;
      start    = 1'b1;
      sb.push_back(v);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      check("latency", lat, v.lat);
   endtask

   always @(posedge clk) begin
      vec_t e;
      #1;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done=1 expected no result pending (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dz);
            check("overflow", overflow, e.ov);
            check("busy_at_done", busy, 1'b0);
         end
      end
   end

   initial begin
      vec_t tbl[16];
      int   lat;
      logic [W-1:0] ra, rb;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      #2 rst = 1'b0;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, '0);
      check("rst_remainder", remainder, '0);
      check("rst_dz", div_by_zero, 1'b0);
      check("rst_ov", overflow, 1'b0);
      @(negedge clk) rst = 1'b1;

      tbl[0]  = mk(2064, 75, 27, 39, 0, 0, 35);
      tbl[1]  = mk(-2064, -48, 43, 0, 0, 0, 35);
      tbl[2]  = mk(-345, 23, 32'hFFFF_FFF1, 0, 0, 0, 35);
      tbl[3]  = mk(-750, 7, 32'hFFFF_FF95, 32'hFFFF_FFFF, 0, 0, 35);
      tbl[4]  = mk(750, -7, -107, 1, 0, 0, 35);
      tbl[5]  = mk(3, 10, 0, 3, 0, 0, 35);
      tbl[6]  = mk(-3, 10, 0, -3, 0, 0, 35);
      tbl[7]  = mk(32'h8000_0000, 1, 32'h8000_0000, 0, 0, 0, 35);
      tbl[8]  = mk(32'h8000_0000, 2, 32'hC000_0000, 0, 0, 0, 35);
      tbl[9]  = mk(32'h8000_0000, 3, -715827882, -2, 0, 0, 35);
      tbl[10] = mk(32'h7FFF_FFFF, -1, 32'h8000_0001, 0, 0, 0, 35);
      tbl[11] = mk(7, 32'h8000_0000, 0, 7, 0, 0, 35);
      tbl[12] = mk(32'h8000_0000, 32'h8000_0000, 1, 0, 0, 0, 35);
      tbl[13] = mk(0, 5, 0, 0, 0, 0, 35);
      tbl[14] = mk(-1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 3);
      tbl[15] = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1, 3);
      for (int i = 0; i < 16; i++) run(tbl[i]);

      // Divide by zero, then overflow: the earlier flag must survive the new start.
      run(mk(10, 0, 32'hFFFF_FFFF, 10, 1, 0, 3));
      @(negedge clk);
      dividend = 32'h8000_0000; divisor = 32'hFFFF_FFFF; start = 1'b1;
      sb.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1, 3));
      @(posedge clk);
      #1 start = 1'b0;
      check("dz_held_after_start", div_by_zero, 1'b1);
      check("busy_in_prep", busy, 1'b1);
      wait_done(lat);
      check("latency_ovf", lat, 3);

      // Start while busy is ignored; start held into DONE chains the next operation.
      @(negedge clk);
      dividend = 100; divisor = 7; start = 1'b1;
      sb.push_back(mk(100, 7, 14, 2, 0, 0, 35));
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      dividend = 9; divisor = 3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_ignored_start", busy, 1'b1);
      repeat (20) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      sb.push_back(mk(9, 3, 3, 0, 0, 0, 35));
      wait_done(lat);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      check("latency_b2b", lat, 35);

      // Reset mid-operation aborts it without a done.
      @(negedge clk);
      dividend = 50; divisor = 50; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #5 rst = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_quotient", quotient, '0);
      check("abort_remainder", remainder, '0);
      check("abort_dz", div_by_zero, 1'b0);
      check("abort_ov", overflow, 1'b0);
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (45) @(posedge clk);
      #1 check("idle_after_abort", busy, 1'b0);
      run(mk(2500, 50, 50, 0, 0, 0, 35));

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 200)) : $urandom;
         if (i == 5) rb = '0;
         if (i == 9) ra = 32'($urandom_range(0, 50));
         run(model(ra, rb));
      end

      repeat (3) @(posedge clk);
      #1 check("queue_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
